ps2_coord_entry: RTL and testbench
==================================

Name: ps2_coord_entry

Overview:
Upstream input stage for the two-player grid game's HEX controller. Receives PS/2 keyboard frames, decodes make codes into a grid coordinate, and drives the letter, number and player_turn values that the HEX controller shows. The coordinate is letter A..J (encoded 0..9) and number 0..9. Enter commits the shot to the game logic through a valid/ready handshake, then the turn passes to the other player.

Parameters:
SYNC_STAGES, 2, flip-flop depth of the ps2_clk/ps2_dat synchronisers (minimum 2).
TIMEOUT_CYCLES, 27000, clock27 cycles (~1 ms) with no PS/2 clock falling edge before a partial frame is abandoned.

Ports:
clock27  input  1  system clock, 27 MHz.
reset  input  1  asynchronous, active-high reset.
ps2_clk  input  1  raw PS/2 clock, asynchronous.
ps2_dat  input  1  raw PS/2 data, asynchronous.
letter  output  4  selected row, 0..9 = A..J; 4'hF = none.
number  output  4  selected column 0..9; 4'hF = none.
player_turn  output  1  0 = player 1, 1 = player 2.
shot_valid  output  1  committed coordinate is available on letter/number.
shot_ready  input  1  game logic accepts the shot.
frame_error  output  1  one-cycle pulse on a bad or abandoned PS/2 frame.

Behaviour:
- Interface: one clock (clock27); reset is asynchronous and active-high. Raw ps2_clk and ps2_dat pass through SYNC_STAGES flip-flops; every edge detection uses the synchronised values.
- Reset values: letter = 4'hF, number = 4'hF, player_turn = 0, shot_valid = 0, frame_error = 0. FSM goes to WAIT_LETTER and the receiver goes idle. Reset mid-frame or mid-handshake discards everything.
- Receiver:
  - Samples data on each synchronised ps2_clk falling edge: start bit (0), 8 data bits LSB first, odd parity, stop bit (1).
  - Byte strobe is issued the cycle after the stop-bit sample, and only if start = 0, parity is odd and stop = 1.
  - Any other result gives no strobe and a one-cycle frame_error.
  - Watchdog: if a frame is in progress and no falling edge arrives for TIMEOUT_CYCLES, the bit counter clears and frame_error pulses once.
- Prefix handling:
  - Byte F0 sets break_pending; the next byte is consumed and ignored.
  - Byte E0 sets ext_pending; the next byte is consumed and ignored, together with any F0 that follows it.
  - Extended keys have no effect.
- Key classes (make codes only):
  - Letters: A 1C, B 32, C 21, D 23, E 24, F 2B, G 34, H 33, I 43, J 3B.
  - Digits: 0 45, 1 16, 2 1E, 3 26, 4 25, 5 2E, 6 36, 7 3D, 8 3E, 9 46.
  - Controls: Enter 5A, Backspace 66, Esc 76.
  - All other codes are ignored.
- FSM (decoded key is applied the cycle after the byte strobe):
  - WAIT_LETTER: letter key loads letter and goes to WAIT_NUMBER. Everything else is ignored.
  - WAIT_NUMBER:
    - letter key overwrites letter;
    - digit loads number and goes to WAIT_ENTER;
    - Backspace sets letter = F and goes to WAIT_LETTER.
  - WAIT_ENTER:
    - digit overwrites number;
    - Backspace sets number = F and goes to WAIT_NUMBER;
    - Enter sets shot_valid = 1 and goes to FIRE.
  - Esc in any state except FIRE: letter = number = F, go to WAIT_LETTER.
  - FIRE:
    - shot_valid stays high; letter and number hold stable; every key is ignored, including Esc.
    - On shot_valid && shot_ready: next cycle shot_valid = 0, player_turn toggles, letter = number = F, state = WAIT_LETTER.
    - If shot_ready is already high on the Enter cycle, the handshake completes on the first cycle of FIRE.
- Typematic repeats of a held key are treated as fresh make codes (idempotent for letter and digit keys).
- letter and number never take values 10..14.

Optional Feature:
KEYPAD_DIGITS_EN.
- Defined: numeric keypad make codes 70,69,72,7A,6B,73,74,6C,75,7D are also accepted as digits 0..9.
- Undefined: these codes are ignored.

Decomposition:
- Shared package ps2_game_pkg holds:
  - scan-code constants (letters, digits, F0, E0, 5A, 66, 76, keypad codes);
  - NONE = 4'hF;
  - the FSM state enum (WAIT_LETTER, WAIT_NUMBER, WAIT_ENTER, FIRE).
- One sub-module, ps2_rx: synchronisers, frame shift register, parity/stop check and watchdog. Outputs are the byte, the byte strobe and frame_error.
- Top level keeps prefix flags, the decoder and the FSM.

Test Plan:
- Frames 1C, 16, 5A, then shot_ready high -> letter = 0, number = 1; shot_valid high for at least 1 cycle; then player_turn = 1 and letter = number = F.
- Frames 3B, F0 3B, 46, 66, 25, 5A -> letter = 9; the break is ignored; number goes 9, then F, then 4; shot_valid asserts.
- Frame 1C sent with even parity -> frame_error pulses once, letter stays F.
- Five bits of a frame, then clock idle for 27000 cycles -> frame_error pulses; a following valid 32 frame gives letter = 1.
- In FIRE with shot_ready low, send 21 and 76 -> letter/number unchanged, shot_valid held; raise shot_ready -> exactly one player_turn toggle.
- Reset asserted mid-frame and during FIRE -> all outputs at reset values immediately. With KEYPAD_DIGITS_EN, 1C then 7D -> number = 9; without it, number stays F.

Source files
------------

// File: rtl/ps2_game_pkg.sv
// Shared definitions for the PS/2 coordinate-entry front end.
// Latency: n/a (constants, types and a pure decode function).
// Backpressure: n/a. Compile with KEYPAD_DIGITS_EN defined to accept keypad digits.
package ps2_game_pkg;

    localparam logic [3:0] NONE = 4'hF;

    // Prefix and control scan codes (set 2)
    localparam logic [7:0] SC_BREAK = 8'hF0;
    localparam logic [7:0] SC_EXT   = 8'hE0;
    localparam logic [7:0] SC_ENTER = 8'h5A;
    localparam logic [7:0] SC_BKSP  = 8'h66;
    localparam logic [7:0] SC_ESC   = 8'h76;

    // Letters A..J
    localparam logic [7:0] SC_A = 8'h1C, SC_B = 8'h32, SC_C = 8'h21, SC_D = 8'h23, SC_E = 8'h24;
    localparam logic [7:0] SC_F = 8'h2B, SC_G = 8'h34, SC_H = 8'h33, SC_I = 8'h43, SC_J = 8'h3B;

    // Main-row digits 0..9
    localparam logic [7:0] SC_0 = 8'h45, SC_1 = 8'h16, SC_2 = 8'h1E, SC_3 = 8'h26, SC_4 = 8'h25;
    localparam logic [7:0] SC_5 = 8'h2E, SC_6 = 8'h36, SC_7 = 8'h3D, SC_8 = 8'h3E, SC_9 = 8'h46;

    // Numeric keypad digits 0..9
    localparam logic [7:0] SC_KP0 = 8'h70, SC_KP1 = 8'h69, SC_KP2 = 8'h72, SC_KP3 = 8'h7A, SC_KP4 = 8'h6B;
    localparam logic [7:0] SC_KP5 = 8'h73, SC_KP6 = 8'h74, SC_KP7 = 8'h6C, SC_KP8 = 8'h75, SC_KP9 = 8'h7D;

    typedef enum logic [1:0] {
        WAIT_LETTER,
        WAIT_NUMBER,
        WAIT_ENTER,
        FIRE
    } state_e;

    typedef enum logic [2:0] {
        KEY_NONE,
        KEY_LETTER,
        KEY_DIGIT,
        KEY_ENTER,
        KEY_BKSP,
        KEY_ESC
    } key_class_e;

    typedef struct packed {
        key_class_e cls;
        logic [3:0] val;   // 0..9 for letters/digits, NONE otherwise
    } key_t;

    function automatic key_t decode_key(input logic [7:0] code);
        key_t k;
        k = '{KEY_NONE, NONE};
        case (code)
            SC_A: k = '{KEY_LETTER, 4'd0};
            SC_B: k = '{KEY_LETTER, 4'd1};
            SC_C: k = '{KEY_LETTER, 4'd2};
            SC_D: k = '{KEY_LETTER, 4'd3};
            SC_E: k = '{KEY_LETTER, 4'd4};
            SC_F: k = '{KEY_LETTER, 4'd5};
            SC_G: k = '{KEY_LETTER, 4'd6};
            SC_H: k = '{KEY_LETTER, 4'd7};
            SC_I: k = '{KEY_LETTER, 4'd8};
            SC_J: k = '{KEY_LETTER, 4'd9};
            SC_0: k = '{KEY_DIGIT, 4'd0};
            SC_1: k = '{KEY_DIGIT, 4'd1};
            SC_2: k = '{KEY_DIGIT, 4'd2};
            SC_3: k = '{KEY_DIGIT, 4'd3};
            SC_4: k = '{KEY_DIGIT, 4'd4};
            SC_5: k = '{KEY_DIGIT, 4'd5};
            SC_6: k = '{KEY_DIGIT, 4'd6};
            SC_7: k = '{KEY_DIGIT, 4'd7};
            SC_8: k = '{KEY_DIGIT, 4'd8};
            SC_9: k = '{KEY_DIGIT, 4'd9};
`ifdef KEYPAD_DIGITS_EN
            SC_KP0: k = '{KEY_DIGIT, 4'd0};
            SC_KP1: k = '{KEY_DIGIT, 4'd1};
            SC_KP2: k = '{KEY_DIGIT, 4'd2};
            SC_KP3: k = '{KEY_DIGIT, 4'd3};
            SC_KP4: k = '{KEY_DIGIT, 4'd4};
            SC_KP5: k = '{KEY_DIGIT, 4'd5};
            SC_KP6: k = '{KEY_DIGIT, 4'd6};
            SC_KP7: k = '{KEY_DIGIT, 4'd7};
            SC_KP8: k = '{KEY_DIGIT, 4'd8};
            SC_KP9: k = '{KEY_DIGIT, 4'd9};
`else
            // keypad codes fall through to KEY_NONE
`endif
            SC_ENTER: k = '{KEY_ENTER, NONE};
            SC_BKSP:  k = '{KEY_BKSP, NONE};
            SC_ESC:   k = '{KEY_ESC, NONE};
            default:  k = '{KEY_NONE, NONE};
        endcase
        return k;
    endfunction

endpackage

// File: rtl/ps2_rx.sv
// PS/2 frame receiver: synchronisers, 11-bit frame capture, parity/stop check, idle watchdog.
// Latency: rx_vld / frame_error one clock27 cycle after the stop-bit falling edge is detected.
// Backpressure: none; rx_vld is a single-cycle strobe that must be consumed when seen.
// Ports: clock27, reset (async, active-high), ps2_clk/ps2_dat (raw, async),
//        rx_dat (received byte), rx_vld (byte strobe), frame_error (bad/abandoned frame pulse).
module ps2_rx
    import ps2_game_pkg::*;
#(
    parameter int SYNC_STAGES    = 2,
    parameter int TIMEOUT_CYCLES = 27000
) (
    input  logic       clock27,
    input  logic       reset,
    input  logic       ps2_clk,
    input  logic       ps2_dat,
    output logic [7:0] rx_dat,
    output logic       rx_vld,
    output logic       frame_error
);

    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    logic [SYNC_STAGES-1:0] clk_sync;
    logic [SYNC_STAGES-1:0] dat_sync;
    logic                   clk_prev;
    logic                   clk_s;
    logic                   dat_s;
    logic                   clk_fall;
    logic [3:0]             bit_cnt;     // 0 = idle, 1..10 = bits captured so far
    logic [9:0]             shreg;       // [0]=start, [8:1]=data, [9]=parity once full
    logic [TW-1:0]          idle_cnt;
    logic                   frame_ok;

    assign clk_s    = clk_sync[SYNC_STAGES-1];
    assign dat_s    = dat_sync[SYNC_STAGES-1];
    assign clk_fall = clk_prev & ~clk_s;
    // Checked on the stop-bit edge: dat_s is the stop bit itself.
    assign frame_ok = ~shreg[0] & (^shreg[9:1]) & dat_s;

    // Synchronisers reset to the idle-high line state so reset never fakes an edge.
    always_ff @(posedge clock27 or posedge reset) begin
        if (reset) begin
            clk_sync <= '1;
            dat_sync <= '1;
            clk_prev <= 1'b1;
        end else begin
            clk_sync <= {clk_sync[SYNC_STAGES-2:0], ps2_clk};
            dat_sync <= {dat_sync[SYNC_STAGES-2:0], ps2_dat};
            clk_prev <= clk_s;
        end
    end

    always_ff @(posedge clock27 or posedge reset) begin
        if (reset) begin
            bit_cnt     <= '0;
            shreg       <= '0;
            idle_cnt    <= '0;
            rx_dat      <= '0;
            rx_vld      <= 1'b0;
            frame_error <= 1'b0;
        end else begin
            rx_vld      <= 1'b0;
            frame_error <= 1'b0;
            if (clk_fall) begin
                idle_cnt <= '0;
                if (bit_cnt == 4'd10) begin
                    bit_cnt     <= '0;
                    rx_dat      <= shreg[8:1];
                    rx_vld      <= frame_ok;
                    frame_error <= ~frame_ok;
                end else begin
                    shreg   <= {dat_s, shreg[9:1]};
                    bit_cnt <= bit_cnt + 4'd1;
                end
            end else if (bit_cnt != 4'd0) begin
                // Partial frame with a stalled clock: abandon it after the timeout.
                if (idle_cnt == TW'(TIMEOUT_CYCLES - 1)) begin
                    idle_cnt    <= '0;
                    bit_cnt     <= '0;
                    frame_error <= 1'b1;
                end else begin
                    idle_cnt <= idle_cnt + 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/ps2_coord_entry.sv
// Keyboard coordinate entry: PS/2 bytes -> letter/number selection -> shot handshake, turn toggle.
// Latency: key effect on letter/number 2 cycles after the byte strobe; shot_valid drops 1 cycle after shot_ready.
// Backpressure: shot_valid holds in FIRE until shot_ready; all keys are dropped meanwhile.
// Ports: clock27, reset (async, active-high), ps2_clk/ps2_dat, letter/number (4'hF = none),
//        player_turn, shot_valid/shot_ready, frame_error. KEYPAD_DIGITS_EN adds keypad digits.
module ps2_coord_entry
    import ps2_game_pkg::*;
#(
    parameter int SYNC_STAGES    = 2,
    parameter int TIMEOUT_CYCLES = 27000
) (
    input  logic       clock27,
    input  logic       reset,
    input  logic       ps2_clk,
    input  logic       ps2_dat,
    output logic [3:0] letter,
    output logic [3:0] number,
    output logic       player_turn,
    output logic       shot_valid,
    input  logic       shot_ready,
    output logic       frame_error
);

    logic [7:0] rx_dat;
    logic       rx_vld;
    logic       break_pending;
    logic       ext_pending;
    logic       key_vld;
    key_t       key;
    state_e     state;

    ps2_rx #(
        .SYNC_STAGES    (SYNC_STAGES),
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_rx (
        .clock27     (clock27),
        .reset       (reset),
        .ps2_clk     (ps2_clk),
        .ps2_dat     (ps2_dat),
        .rx_dat      (rx_dat),
        .rx_vld      (rx_vld),
        .frame_error (frame_error)
    );

    // Prefix filter: only bare make codes reach the decoder. An extended prefix
    // also swallows a following F0 so "E0 F0 xx" releases are dropped whole.
    always_ff @(posedge clock27 or posedge reset) begin
        if (reset) begin
            break_pending <= 1'b0;
            ext_pending   <= 1'b0;
            key_vld       <= 1'b0;
            key           <= '{KEY_NONE, NONE};
        end else begin
            key_vld <= 1'b0;
            if (rx_vld) begin
                if (ext_pending) begin
                    if (rx_dat != SC_BREAK)
                        ext_pending <= 1'b0;
                end else if (break_pending) begin
                    break_pending <= 1'b0;
                end else if (rx_dat == SC_EXT) begin
                    ext_pending <= 1'b1;
                end else if (rx_dat == SC_BREAK) begin
                    break_pending <= 1'b1;
                end else begin
                    key_vld <= 1'b1;
                    key     <= decode_key(rx_dat);
                end
            end
        end
    end

    always_ff @(posedge clock27 or posedge reset) begin
        if (reset) begin
            state       <= WAIT_LETTER;
            letter      <= NONE;
            number      <= NONE;
            player_turn <= 1'b0;
            shot_valid  <= 1'b0;
        end else if (state == FIRE) begin
            if (shot_valid && shot_ready) begin
                shot_valid  <= 1'b0;
                player_turn <= ~player_turn;
                letter      <= NONE;
                number      <= NONE;
                state       <= WAIT_LETTER;
            end
        end else if (key_vld) begin
            if (key.cls == KEY_ESC) begin
                letter <= NONE;
                number <= NONE;
                state  <= WAIT_LETTER;
            end else begin
                case (state)
                    WAIT_LETTER: begin
                        if (key.cls == KEY_LETTER) begin
                            letter <= key.val;
                            state  <= WAIT_NUMBER;
                        end
                    end
                    WAIT_NUMBER: begin
                        if (key.cls == KEY_LETTER) begin
                            letter <= key.val;
                        end else if (key.cls == KEY_DIGIT) begin
                            number <= key.val;
                            state  <= WAIT_ENTER;
                        end else if (key.cls == KEY_BKSP) begin
                            letter <= NONE;
                            state  <= WAIT_LETTER;
                        end
                    end
                    WAIT_ENTER: begin
                        if (key.cls == KEY_DIGIT) begin
                            number <= key.val;
                        end else if (key.cls == KEY_BKSP) begin
                            number <= NONE;
                            state  <= WAIT_NUMBER;
                        end else if (key.cls == KEY_ENTER) begin
                            shot_valid <= 1'b1;
                            state      <= FIRE;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_ps2_coord_entry.sv
module tb_ps2_coord_entry;

    logic       clock27 = 1'b0;
    logic       reset = 1'b1;
    logic       ps2_clk = 1'b1;
    logic       ps2_dat = 1'b1;
    logic [3:0] letter;
    logic [3:0] number;
    logic       player_turn;
    logic       shot_valid;
    logic       shot_ready = 1'b0;
    logic       frame_error;

    int n_checks = 0;
    int n_fail = 0;
    int err_cnt = 0;
    logic exp_turn = 1'b0;

    typedef struct {
        logic [3:0] l;
        logic [3:0] n;
        logic       t;
    } shot_t;
    shot_t exp_q[$];

    always #5 clock27 = ~clock27;

    ps2_coord_entry dut (
        .clock27     (clock27),
        .reset       (reset),
        .ps2_clk     (ps2_clk),
        .ps2_dat     (ps2_dat),
        .letter      (letter),
        .number      (number),
        .player_turn (player_turn),
        .shot_valid  (shot_valid),
        .shot_ready  (shot_ready),
        .frame_error (frame_error)
    );

    // Monitor: counts frame_error pulses and scores every completed shot handshake.
    always @(negedge clock27) begin
        if (!reset) begin
            if (frame_error) err_cnt++;
            if (shot_valid && shot_ready) begin
                shot_t e;
                n_checks++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL shot_unexpected: got L=%0h N=%0h T=%0b, required no shot", letter, number, player_turn);
                end else begin
                    e = exp_q.pop_front();
                    if (letter !== e.l || number !== e.n || player_turn !== e.t) begin
                        n_fail++;
                        $display("FAIL shot_data: got L=%0h N=%0h T=%0b, required L=%0h N=%0h T=%0b",
                                 letter, number, player_turn, e.l, e.n, e.t);
                    end
                end
            end
        end
    end

    // Sends the first nbits of a PS/2 frame (start, 8 data LSB first, odd parity, stop).
    task automatic send_bits(input logic [7:0] b, input logic bad_par, input int nbits);
        logic [10:0] fr;
        fr = {1'b1, (~^b) ^ bad_par, b, 1'b0};
        for (int i = 0; i < nbits; i++) begin
            @(negedge clock27);
            ps2_dat = fr[i];
            repeat (4) @(negedge clock27);
            ps2_clk = 1'b0;
            repeat (8) @(negedge clock27);
            ps2_clk = 1'b1;
            repeat (4) @(negedge clock27);
        end
        ps2_dat = 1'b1;
        repeat (8) @(negedge clock27);
    endtask

    task automatic send_key(input logic [7:0] b);
        send_bits(b, 1'b0, 11);
    endtask

    task automatic wait_handshake(input string name);
        for (int i = 0; i < 40 && shot_valid; i++) @(negedge clock27);
        n_checks++;
        if (shot_valid) begin
            n_fail++;
            $display("FAIL %s_timeout: shot_valid still %0b, required 0 within 40 cycles", name, shot_valid);
        end
    endtask

    task automatic check_sel(input string name, input logic [3:0] l, input logic [3:0] n);
        n_checks++;
        if (letter !== l || number !== n) begin
            n_fail++;
            $display("FAIL %s: got L=%0h N=%0h, required L=%0h N=%0h", name, letter, number, l, n);
        end
    endtask

    task automatic test_reset;
        reset = 1'b1;
        repeat (3) @(negedge clock27);
        n_checks += 5;
        if (letter !== 4'hF) begin n_fail++; $display("FAIL reset_letter: got %0h, required f", letter); end
        if (number !== 4'hF) begin n_fail++; $display("FAIL reset_number: got %0h, required f", number); end
        if (player_turn !== 1'b0) begin n_fail++; $display("FAIL reset_turn: got %0b, required 0", player_turn); end
        if (shot_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %0b, required 0", shot_valid); end
        if (frame_error !== 1'b0) begin n_fail++; $display("FAIL reset_ferr: got %0b, required 0", frame_error); end
        reset = 1'b0;
        repeat (4) @(negedge clock27);
    endtask

    task automatic test_basic_shot;
        shot_ready = 1'b0;
        send_key(8'h1C);
        check_sel("basic_letter", 4'h0, 4'hF);
        send_key(8'h16);
        check_sel("basic_number", 4'h0, 4'h1);
        send_key(8'h5A);
        n_checks++;
        if (shot_valid !== 1'b1) begin n_fail++; $display("FAIL basic_valid: got %0b, required 1", shot_valid); end
        exp_q.push_back('{4'h0, 4'h1, exp_turn});
        shot_ready = 1'b1;
        wait_handshake("basic");
        shot_ready = 1'b0;
        exp_turn = ~exp_turn;
        n_checks++;
        if (player_turn !== exp_turn) begin n_fail++; $display("FAIL basic_turn: got %0b, required %0b", player_turn, exp_turn); end
        check_sel("basic_cleared", 4'hF, 4'hF);
    endtask

    task automatic test_edit;
        send_key(8'h3B);
        check_sel("edit_letter", 4'h9, 4'hF);
        send_key(8'hF0);
        send_key(8'h3B);
        check_sel("edit_break", 4'h9, 4'hF);
        send_key(8'h46);
        check_sel("edit_num9", 4'h9, 4'h9);
        send_key(8'h66);
        check_sel("edit_bksp", 4'h9, 4'hF);
        send_key(8'h25);
        check_sel("edit_num4", 4'h9, 4'h4);
        send_key(8'h5A);
        n_checks++;
        if (shot_valid !== 1'b1) begin n_fail++; $display("FAIL edit_valid: got %0b, required 1", shot_valid); end
        exp_q.push_back('{4'h9, 4'h4, exp_turn});
        shot_ready = 1'b1;
        wait_handshake("edit");
        shot_ready = 1'b0;
        exp_turn = ~exp_turn;
    endtask

    task automatic test_parity_error;
        int e0;
        e0 = err_cnt;
        send_bits(8'h1C, 1'b1, 11);
        n_checks++;
        if (err_cnt !== e0 + 1) begin n_fail++; $display("FAIL parity_ferr: got %0d pulses, required 1", err_cnt - e0); end
        check_sel("parity_letter", 4'hF, 4'hF);
    endtask

    task automatic test_timeout;
        int e0;
        e0 = err_cnt;
        send_bits(8'h32, 1'b0, 5);
        n_checks++;
        if (err_cnt !== e0) begin n_fail++; $display("FAIL timeout_early: got %0d pulses, required 0", err_cnt - e0); end
        repeat (27100) @(negedge clock27);
        n_checks++;
        if (err_cnt !== e0 + 1) begin n_fail++; $display("FAIL timeout_ferr: got %0d pulses, required 1", err_cnt - e0); end
        send_key(8'h32);
        check_sel("timeout_recover", 4'h1, 4'hF);
        send_key(8'h76);
        check_sel("timeout_esc", 4'hF, 4'hF);
    endtask

    task automatic test_fire_hold;
        logic t0;
        send_key(8'h1C);
        send_key(8'h45);
        send_key(8'h5A);
        send_key(8'h21);
        send_key(8'h76);
        check_sel("fire_hold_sel", 4'h0, 4'h0);
        n_checks++;
        if (shot_valid !== 1'b1) begin n_fail++; $display("FAIL fire_hold_valid: got %0b, required 1", shot_valid); end
        t0 = player_turn;
        exp_q.push_back('{4'h0, 4'h0, exp_turn});
        shot_ready = 1'b1;
        wait_handshake("fire_hold");
        repeat (20) @(negedge clock27);
        shot_ready = 1'b0;
        exp_turn = ~exp_turn;
        n_checks++;
        if (player_turn !== ~t0 || player_turn !== exp_turn) begin
            n_fail++;
            $display("FAIL fire_hold_turn: got %0b, required %0b", player_turn, exp_turn);
        end
    endtask

    task automatic test_ready_early;
        shot_ready = 1'b1;
        send_key(8'h24);
        send_key(8'h2E);
        check_sel("early_sel", 4'h4, 4'h5);
        exp_q.push_back('{4'h4, 4'h5, exp_turn});
        send_key(8'h5A);
        shot_ready = 1'b0;
        exp_turn = ~exp_turn;
        n_checks += 2;
        if (shot_valid !== 1'b0) begin n_fail++; $display("FAIL early_valid: got %0b, required 0", shot_valid); end
        if (player_turn !== exp_turn) begin n_fail++; $display("FAIL early_turn: got %0b, required %0b", player_turn, exp_turn); end
    endtask

    task automatic test_prefixes;
        send_key(8'hE0);
        send_key(8'h1C);
        check_sel("ext_make", 4'hF, 4'hF);
        send_key(8'hE0);
        send_key(8'hF0);
        send_key(8'h1C);
        check_sel("ext_break", 4'hF, 4'hF);
        send_key(8'hF0);
        send_key(8'h1C);
        check_sel("break_ignored", 4'hF, 4'hF);
        send_key(8'h1C);
        check_sel("after_prefix", 4'h0, 4'hF);
        send_key(8'h76);
    endtask

    task automatic test_keypad;
        send_key(8'h1C);
        send_key(8'h7D);
`ifdef KEYPAD_DIGITS_EN
        check_sel("keypad_digit", 4'h0, 4'h9);
`else
        check_sel("keypad_digit", 4'h0, 4'hF);
`endif
        send_key(8'h76);
        check_sel("keypad_esc", 4'hF, 4'hF);
    endtask

    task automatic test_reset_mid;
        send_bits(8'h1C, 1'b0, 4);
        @(negedge clock27);
        reset = 1'b1;
        #1;
        check_sel("rst_frame_sel", 4'hF, 4'hF);
        ps2_clk = 1'b1;
        ps2_dat = 1'b1;
        repeat (3) @(negedge clock27);
        reset = 1'b0;
        repeat (3) @(negedge clock27);
        send_key(8'h1C);
        check_sel("rst_frame_recover", 4'h0, 4'hF);
        send_key(8'h16);
        send_key(8'h5A);
        n_checks++;
        if (shot_valid !== 1'b1) begin n_fail++; $display("FAIL rst_fire_valid: got %0b, required 1", shot_valid); end
        @(negedge clock27);
        reset = 1'b1;
        #1;
        exp_turn = 1'b0;
        n_checks += 2;
        if (shot_valid !== 1'b0) begin n_fail++; $display("FAIL rst_fire_clear: got %0b, required 0", shot_valid); end
        if (player_turn !== 1'b0) begin n_fail++; $display("FAIL rst_fire_turn: got %0b, required 0", player_turn); end
        check_sel("rst_fire_sel", 4'hF, 4'hF);
        repeat (3) @(negedge clock27);
        reset = 1'b0;
        repeat (3) @(negedge clock27);
    endtask

    initial begin
        test_reset();
        test_basic_shot();
        test_edit();
        test_parity_error();
        test_timeout();
        test_fire_hold();
        test_ready_early();
        test_prefixes();
        test_keypad();
        test_reset_mid();
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL shots_missing: got %0d unmatched expected shots, required 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
